// File: rtl/simplecpu_pkg.sv
// Shared definitions for the data-memory arbiter: default bus widths and
// the arbiter FSM state encoding.
package simplecpu_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between the CPU (port 0) and loader/debug (port 1).
// Optional feature macro: DMEM_ARB_RR_EN (round-robin ties, else port 0 wins).
// Ports:
//   req0, req1 : pending requests
//   ptr        : index of the most recent winner (ignored in fixed priority)
//   winner     : selected port index, combinational
import simplecpu_pkg::*;

module dmem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic winner
);

`ifdef DMEM_ARB_RR_EN
  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~ptr;
    end else if (req1) begin
      winner = 1'b1;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr;

  // Fixed priority: port 1 only wins when port 0 is not asking.
  always_comb begin
    winner = 1'b0;
    if (!req0 && req1) begin
      winner = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory with combinational
// read data and negedge writes. Each transaction is one IDLE->ACCESS->IDLE
// round trip; reads return on rdata/rvalid of the winning port.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin tie-break with pointer).
// Ports:
//   clk, rst                              : clock, async active-high reset
//   req/we/addr/wdata{0,1}                : requester inputs (0 = CPU, 1 = loader)
//   gnt/rvalid/rdata{0,1}                 : requester outputs
//   mem_raddr, mem_waddr, mem_we, mem_din : memory command
//   mem_dout                              : memory read data (combinational)
//   busy, owner                           : in ACCESS / latched winner index
import simplecpu_pkg::*;

module dmem_arbiter #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              owner
);

  state_t state_q;
  state_t state_d;

  logic              win;
  logic              ptr;
  logic              start;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q;

  // Pointer remembers the last winner; advances on every accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (start) begin
      ptr_q <= win;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  dmem_arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .ptr    (ptr),
    .winner (win)
  );

  assign start     = (state_q == IDLE) && (req0 || req1);
  assign sel_we    = win ? we1 : we0;
  assign sel_addr  = win ? addr1 : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ACCESS always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: the memory command registers double as the latched
  // request, so they naturally hold their value through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (start) begin
        mem_raddr <= sel_addr;
        mem_waddr <= sel_addr;
        mem_din   <= sel_wdata;
        mem_we    <= sel_we;
        gnt0      <= ~win;
        gnt1      <= win;
        busy      <= 1'b1;
        owner     <= win;
      end else if (state_q == ACCESS) begin
        mem_we <= 1'b0;
        gnt0   <= 1'b0;
        gnt1   <= 1'b0;
        busy   <= 1'b0;
        // mem_we still holds the latched we for the transaction ending here.
        if (!mem_we) begin
          if (owner) begin
            rdata1  <= mem_dout;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_dout;
            rvalid0 <= 1'b1;
          end
        end
      end
    end
  end

endmodule
